zombie_wave_controller: RTL and testbench
=========================================

# zombie_wave_controller

Parametrised wave manager for N zombie channels. It replaces the fixed three-zombie spawn-delay and kill bookkeeping, and the hand-built `enemies` reduction, in the final-project top level. It is clocked on `Clk` and counts frames from `VGA_VS`. On each `new_level` pulse it arms every enabled channel with its own spawn delay, releases each channel when its delay expires, and latches kills reported by `collisions`. It also keeps a saturating score and emits a one-cycle wave-clear pulse for `Game_state`.

## Interface
Parameters:
- `N_ZOMBIES`, 3: number of channels, legal range 1..16.
- `DELAY_W`, 10: width of each spawn-delay field, in frames.
- `SCORE_W`, 8: width of the score counter.

Ports:
- `Clk`, in, 1: system clock, 50 MHz.
- `Reset`, in, 1: asynchronous, active-high reset.
- `frame_clk`, in, 1: `VGA_VS`, asynchronous to `Clk`.
- `new_level`, in, 1: one-cycle pulse that starts a wave.
- `spawn_enable`, in, N_ZOMBIES: channels that take part in the wave. Sampled on `new_level`.
- `delay_spawn`, in, N_ZOMBIES*DELAY_W: per-channel delay in frames. Channel i occupies bits [i*DELAY_W +: DELAY_W]. Sampled on `new_level`.
- `is_dead`, in, N_ZOMBIES: hit indication from `collisions`, level or pulse.
- `is_alive`, out, N_ZOMBIES: channel is on screen and chasing.
- `is_killed`, out, N_ZOMBIES: channel is killed or not participating.
- `enemies`, out, 1: at least one channel is waiting or alive.
- `alive_count`, out, $clog2(N_ZOMBIES+1): number of channels currently alive.
- `score`, out, SCORE_W: cumulative kills.
- `wave_clear`, out, 1: one-cycle pulse when the wave ends.

## Operation
- **Frame tick.** `frame_clk` passes through a 2-flop synchroniser. Its rising edge produces `frame_tick`, exactly one `Clk` cycle wide.
- **Per-channel states:** OFF, WAIT, ALIVE, KILLED.
  - OFF → WAIT on `new_level` with `spawn_enable[i]`=1. The counter loads `delay_spawn[i]`.
  - OFF → OFF on `new_level` with `spawn_enable[i]`=0.
  - WAIT: on `frame_tick` with counter > 0, decrement. WAIT → ALIVE on `frame_tick` with counter == 0. A loaded delay of 0 therefore spawns on the first frame tick.
  - ALIVE → KILLED when `is_dead[i]`=1.
  - From any state, `new_level` reloads the channel exactly as for OFF.
- **Outputs** (all registered or decoded directly from state registers):
  - `is_alive[i]` = (state == ALIVE).
  - `is_killed[i]` = (state ∈ {KILLED, OFF}).
  - `enemies` = OR over channels of (WAIT or ALIVE).
- **Score.** Each cycle, add popcount of the ALIVE→KILLED transitions. Saturate at 2^SCORE_W−1; never wrap. Only `Reset` clears the score; `new_level` does not.
- **wave_clear** pulses for one cycle when `enemies` goes 1→0. If a wave starts with no channels enabled, `enemies` stays 0 and no pulse is produced.

## Timing
- **Reset values:** all channels OFF, so `is_alive`=0 and `is_killed`=all 1s. `enemies`=0, `alive_count`=0, `score`=0, `wave_clear`=0. Counters are 0.
- **Reset mid-wave** drops every channel to OFF immediately (asynchronous). No `wave_clear` pulse is produced.
- **Tick latency:** `frame_clk` rising edge to `frame_tick` is 2–3 `Clk` cycles. A state change driven by a tick is visible one cycle after `frame_tick`.
- **Kill latency:** `is_dead` sampled high in ALIVE gives KILLED, the score update and the `alive_count` change on the next edge. `wave_clear` follows one cycle after `enemies` falls.
- **Ignored `is_dead`:** in WAIT, KILLED or OFF, `is_dead` has no effect. A level held high does not re-score.
- **`new_level` priority:** it takes precedence over a same-cycle `is_dead` or `frame_tick` on every channel. That kill is not scored.
- **Simultaneous kills** in one cycle add their full count, subject to saturation.

## Structure
- **Package `zombie_pkg`:** the `slot_state_t` enum (OFF, WAIT, ALIVE, KILLED) and the default constants `N_ZOMBIES_DEF`, `DELAY_W_DEF` and `SCORE_W_DEF`.
- **Sub-module `zombie_slot`:** one per channel, created by generate loop. It holds the state register and delay counter and outputs `alive`, `killed`, `pending` and a `kill_event` pulse.
- **Top module:** the synchroniser, popcount and score adder, `alive_count` reduction, and `wave_clear` edge detector.

## Test plan
- **Reset and spawn.** Reset, then `new_level` with `spawn_enable`=3'b111 and delays {0,2,5}. Channel 0 is alive 1 cycle after the first tick; channel 1 after tick 3; channel 2 after tick 6. `alive_count` steps 1→2→3.
- **Kill and clear.** Kill all three over separate cycles. `score`=3, `is_killed`=3'b111 and `enemies`=0, and `wave_clear` is high for exactly one cycle.
- **Simultaneous kills and saturation.** With SCORE_W=2 and score at 2, kill two channels in the same cycle. `score`=3 (saturated), not 0.
- **Race and ignored hits.** Assert `is_dead` during WAIT: no state or score change. Assert `new_level` and `is_dead` together: the channel reloads to WAIT and the score is unchanged.
- **Partial enable.** `spawn_enable`=3'b010: channels 0 and 2 stay OFF with `is_killed`=1; `enemies` tracks channel 1 only.
- **Async reset mid-wave.** Assert `Reset` between clock edges while channels are alive. All outputs reach their reset values immediately and no `wave_clear` pulse occurs.

Source files
------------

// File: rtl/zombie_pkg.sv
// Shared types and default sizing for the zombie wave controller.
package zombie_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WAIT   = 2'd1,
        ALIVE  = 2'd2,
        KILLED = 2'd3
    } slot_state_t;

    localparam int N_ZOMBIES_DEF = 3;
    localparam int DELAY_W_DEF   = 10;
    localparam int SCORE_W_DEF   = 8;

endpackage

// File: rtl/zombie_slot.sv
// One zombie channel: lifecycle state plus spawn-delay countdown in frames.
module zombie_slot
    import zombie_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_level,
    input  logic               enable,
    input  logic [DELAY_W-1:0] delay,
    input  logic               frame_tick,
    input  logic               is_dead,
    output logic               alive,
    output logic               killed,
    output logic               pending,
    output logic               kill_event
);

    slot_state_t        state_r, state_s;
    logic [DELAY_W-1:0] cnt_r, cnt_s;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= OFF;
            cnt_r   <= {DELAY_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; new_level overrides any same-cycle tick or hit.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        kill_event = 1'b0;
        if (new_level) begin
            if (enable) begin
                state_s = WAIT;
                cnt_s   = delay;
            end else begin
                state_s = OFF;
                cnt_s   = {DELAY_W{1'b0}};
            end
        end else begin
            case (state_r)
                WAIT: begin
                    if (frame_tick) begin
                        if (cnt_r == {DELAY_W{1'b0}}) begin
                            state_s = ALIVE;
                        end else begin
                            cnt_s = cnt_r - {{(DELAY_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s = WAIT;
                    end
                end
                ALIVE: begin
                    if (is_dead) begin
                        state_s    = KILLED;
                        kill_event = 1'b1;
                    end else begin
                        state_s = ALIVE;
                    end
                end
                default: state_s = state_r;
            endcase
        end
    end

    assign alive   = (state_r == ALIVE);
    assign killed  = (state_r == KILLED) || (state_r == OFF);
    assign pending = (state_r == WAIT) || (state_r == ALIVE);

endmodule

// File: rtl/zombie_wave_controller.sv
// Wave manager: frame-tick synchroniser, N zombie channels, saturating score
// and wave-clear pulse generation.
module zombie_wave_controller
    import zombie_pkg::*;
#(
    parameter  int N_ZOMBIES = N_ZOMBIES_DEF,
    parameter  int DELAY_W   = DELAY_W_DEF,
    parameter  int SCORE_W   = SCORE_W_DEF,
    localparam int CNT_W     = $clog2(N_ZOMBIES + 1)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic                         new_level,
    input  logic [N_ZOMBIES-1:0]         spawn_enable,
    input  logic [N_ZOMBIES*DELAY_W-1:0] delay_spawn,
    input  logic [N_ZOMBIES-1:0]         is_dead,
    output logic [N_ZOMBIES-1:0]         is_alive,
    output logic [N_ZOMBIES-1:0]         is_killed,
    output logic                         enemies,
    output logic [CNT_W-1:0]             alive_count,
    output logic [SCORE_W-1:0]           score,
    output logic                         wave_clear
);

    localparam int SUM_W = SCORE_W + CNT_W;

    logic [2:0]           sync_r;
    logic                 frame_tick_s;
    logic [N_ZOMBIES-1:0] pending_s;
    logic [N_ZOMBIES-1:0] kill_s;
    logic [CNT_W-1:0]     kills_s;
    logic [CNT_W-1:0]     alive_count_s;
    logic [SUM_W-1:0]     sum_s;
    logic [SCORE_W-1:0]   score_r, score_s;
    logic                 enemies_r;
    logic                 wave_clear_r;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], frame_clk};
        end
    end

    assign frame_tick_s = sync_r[1] & ~sync_r[2];

    for (genvar g = 0; g < N_ZOMBIES; g++) begin : g_slot
        zombie_slot #(.DELAY_W(DELAY_W)) u_slot (
            .clk        (Clk),
            .rst        (Reset),
            .new_level  (new_level),
            .enable     (spawn_enable[g]),
            .delay      (delay_spawn[g*DELAY_W +: DELAY_W]),
            .frame_tick (frame_tick_s),
            .is_dead    (is_dead[g]),
            .alive      (is_alive[g]),
            .killed     (is_killed[g]),
            .pending    (pending_s[g]),
            .kill_event (kill_s[g])
        );
    end

    // Popcounts of this cycle's kills and of the currently alive channels.
    always_comb begin
        kills_s       = {CNT_W{1'b0}};
        alive_count_s = {CNT_W{1'b0}};
        for (int i = 0; i < N_ZOMBIES; i++) begin
            kills_s       = kills_s + CNT_W'(kill_s[i]);
            alive_count_s = alive_count_s + CNT_W'(is_alive[i]);
        end
    end

    // Saturating score add; the wide sum cannot overflow before the clamp.
    always_comb begin
        sum_s = {{CNT_W{1'b0}}, score_r} + {{SCORE_W{1'b0}}, kills_s};
        if (sum_s > {{CNT_W{1'b0}}, {SCORE_W{1'b1}}}) begin
            score_s = {SCORE_W{1'b1}};
        end else begin
            score_s = sum_s[SCORE_W-1:0];
        end
    end

    // Score register and enemies falling-edge detector for wave_clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score_r      <= {SCORE_W{1'b0}};
            enemies_r    <= 1'b0;
            wave_clear_r <= 1'b0;
        end else begin
            score_r      <= score_s;
            enemies_r    <= enemies;
            wave_clear_r <= enemies_r & ~enemies;
        end
    end

    assign enemies     = |pending_s;
    assign alive_count = alive_count_s;
    assign score       = score_r;
    assign wave_clear  = wave_clear_r;

endmodule

// File: tb/tb_zombie_wave_controller.sv
// Directed self-checking bench: a default-width instance and a 2-bit-score
// instance driven by the same stimulus.
module tb_zombie_wave_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        new_level = 1'b0;
    logic [2:0]  spawn_enable = 3'b000;
    logic [29:0] delay_spawn = 30'd0;
    logic [2:0]  is_dead = 3'b000;

    logic [2:0]  is_alive, is_killed;
    logic        enemies, wave_clear;
    logic [1:0]  alive_count;
    logic [7:0]  score;

    logic [2:0]  is_alive_b, is_killed_b;
    logic        enemies_b, wave_clear_b;
    logic [1:0]  alive_count_b;
    logic [1:0]  score_b;

    int checks = 0;
    int errors = 0;
    int wc_cnt = 0;
    int wc_ref;

    always #5 Clk = ~Clk;

    zombie_wave_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .new_level(new_level),
        .spawn_enable(spawn_enable), .delay_spawn(delay_spawn), .is_dead(is_dead),
        .is_alive(is_alive), .is_killed(is_killed), .enemies(enemies),
        .alive_count(alive_count), .score(score), .wave_clear(wave_clear)
    );

    zombie_wave_controller #(.SCORE_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .new_level(new_level),
        .spawn_enable(spawn_enable), .delay_spawn(delay_spawn), .is_dead(is_dead),
        .is_alive(is_alive_b), .is_killed(is_killed_b), .enemies(enemies_b),
        .alive_count(alive_count_b), .score(score_b), .wave_clear(wave_clear_b)
    );

    // Count cycles in which the main instance signals wave_clear.
    always @(negedge Clk) begin
        if (wave_clear) wc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_wave(input logic [2:0] en, input logic [29:0] d);
        new_level    = 1'b1;
        spawn_enable = en;
        delay_spawn  = d;
        @(negedge Clk);
        new_level = 1'b0;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic kill(input logic [2:0] m, input int hold);
        is_dead = m;
        repeat (hold) @(negedge Clk);
        is_dead = 3'b000;
    endtask

    initial begin
        @(negedge Clk);
        chk("rst_alive",  32'(is_alive), 32'h0);
        chk("rst_killed", 32'(is_killed), 32'h7);
        chk("rst_enemies", 32'(enemies), 32'h0);
        chk("rst_count",  32'(alive_count), 32'h0);
        chk("rst_score",  32'(score), 32'h0);
        chk("rst_wclear", 32'(wave_clear), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Spawn with delays ch0=0, ch1=2, ch2=5.
        start_wave(3'b111, {10'd5, 10'd2, 10'd0});
        chk("wait_enemies", 32'(enemies), 32'h1);
        chk("wait_killed", 32'(is_killed), 32'h0);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        chk("tick1_early", 32'(is_alive), 32'h0);
        repeat (2) @(negedge Clk);
        chk("tick1_alive", 32'(is_alive), 32'h1);
        chk("tick1_count", 32'(alive_count), 32'h1);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        tick();
        chk("tick2_alive", 32'(is_alive), 32'h1);
        tick();
        chk("tick3_alive", 32'(is_alive), 32'h3);
        chk("tick3_count", 32'(alive_count), 32'h2);
        tick();
        tick();
        chk("tick5_alive", 32'(is_alive), 32'h3);
        tick();
        chk("tick6_alive", 32'(is_alive), 32'h7);
        chk("tick6_count", 32'(alive_count), 32'h3);

        // Sequential kills; ch0 hit held for two cycles scores once.
        wc_ref = wc_cnt;
        kill(3'b001, 2);
        chk("kill0_score", 32'(score), 32'h1);
        chk("kill0_alive", 32'(is_alive), 32'h6);
        chk("kill0_count", 32'(alive_count), 32'h2);
        kill(3'b010, 1);
        chk("kill1_score", 32'(score), 32'h2);
        is_dead = 3'b100;
        @(negedge Clk);
        is_dead = 3'b000;
        chk("kill2_score", 32'(score), 32'h3);
        chk("kill2_killed", 32'(is_killed), 32'h7);
        chk("kill2_enemies", 32'(enemies), 32'h0);
        chk("kill2_wc_lag", 32'(wave_clear), 32'h0);
        @(negedge Clk);
        chk("wc_pulse", 32'(wave_clear), 32'h1);
        @(negedge Clk);
        chk("wc_drop", 32'(wave_clear), 32'h0);
        repeat (3) @(negedge Clk);
        chk("wc_once", 32'(wc_cnt - wc_ref), 32'h1);
        chk("sat_score_w1", 32'(score_b), 32'h3);

        // Hits during WAIT are ignored.
        start_wave(3'b111, 30'd0);
        kill(3'b111, 1);
        chk("waithit_alive", 32'(is_alive), 32'h0);
        chk("waithit_killed", 32'(is_killed), 32'h0);
        chk("waithit_score", 32'(score), 32'h3);
        tick();
        chk("respawn_alive", 32'(is_alive), 32'h7);

        // new_level beats a same-cycle hit; kill not scored.
        wc_ref = wc_cnt;
        is_dead = 3'b111;
        start_wave(3'b111, 30'd0);
        is_dead = 3'b000;
        chk("race_alive", 32'(is_alive), 32'h0);
        chk("race_killed", 32'(is_killed), 32'h0);
        chk("race_enemies", 32'(enemies), 32'h1);
        @(negedge Clk);
        chk("race_score", 32'(score), 32'h3);
        tick();
        chk("race_respawn", 32'(is_alive), 32'h7);
        chk("race_no_wc", 32'(wc_cnt - wc_ref), 32'h0);

        // Asynchronous reset between edges while all channels are alive.
        #2 Reset = 1'b1;
        #1;
        chk("arst_alive", 32'(is_alive), 32'h0);
        chk("arst_killed", 32'(is_killed), 32'h7);
        chk("arst_enemies", 32'(enemies), 32'h0);
        chk("arst_count", 32'(alive_count), 32'h0);
        chk("arst_score", 32'(score), 32'h0);
        chk("arst_wclear", 32'(wave_clear), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        chk("arst_no_wc", 32'(wc_cnt - wc_ref), 32'h0);

        // Empty wave: no enemies, no pulse.
        start_wave(3'b000, 30'd0);
        repeat (4) @(negedge Clk);
        chk("empty_enemies", 32'(enemies), 32'h0);
        chk("empty_killed", 32'(is_killed), 32'h7);
        chk("empty_no_wc", 32'(wc_cnt - wc_ref), 32'h0);

        // Partial enable: only ch1 (delay 1) takes part.
        start_wave(3'b010, {10'd0, 10'd1, 10'd0});
        chk("part_killed", 32'(is_killed), 32'h5);
        chk("part_enemies", 32'(enemies), 32'h1);
        tick();
        chk("part_tick1", 32'(is_alive), 32'h0);
        tick();
        chk("part_tick2", 32'(is_alive), 32'h2);
        kill(3'b111, 1);
        chk("part_enemies_off", 32'(enemies), 32'h0);
        chk("part_score", 32'(score), 32'h1);
        repeat (3) @(negedge Clk);
        chk("part_wc", 32'(wc_cnt - wc_ref), 32'h1);

        // Bring the 2-bit score to 2, then two simultaneous kills.
        start_wave(3'b001, 30'd0);
        tick();
        kill(3'b001, 1);
        chk("pre_sat_b", 32'(score_b), 32'h2);
        start_wave(3'b111, 30'd0);
        tick();
        kill(3'b011, 1);
        chk("simul_score", 32'(score), 32'h4);
        chk("simul_sat_b", 32'(score_b), 32'h3);
        chk("simul_count", 32'(alive_count), 32'h1);
        kill(3'b100, 1);
        chk("last_score", 32'(score), 32'h5);
        chk("last_sat_b", 32'(score_b), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
